tone_generator: RTL and testbench

- Downstream stage of the learn/play note sequencer; converts the note code and octave it emits into a square wave on the buzzer pin.
- Adds a short silent articulation gap whenever the note or octave changes, so that repeated and consecutive notes are audibly separated.
- Drives one output, `speaker`, plus status for LEDs and debug.

---
 rtl/tone_generator.sv | 135 +++++++++++++
 tb/tb_tone_generator.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/tone_generator.sv
// tone_generator: turns the sequencer's note code and octave into a square
// wave on the buzzer pin. A silent articulation gap is inserted on every
// note/octave change so consecutive and repeated notes stay audibly distinct.
module tone_generator #(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned GAP_CYCLES = 1_000_000,
  parameter int unsigned CNT_W      = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] note_in,
  input  logic [1:0] octave_in,
  output logic       speaker,
  output logic       active,
  output logic [3:0] cur_note
);

  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, GAP, TONE} state_t;

  state_t           state;
  logic [3:0]       note_q;
  logic [1:0]       oct_q;
  logic [GW-1:0]    gap_cnt;
  logic [CNT_W-1:0] half_cnt;
  logic [CNT_W-1:0] eff_half;
  logic             change;
  logic             tgt_snd;

  // Middle-octave half-period for a note code; all operands are elaboration
  // constants so each branch folds to a literal.
  function automatic int unsigned half_of(input logic [3:0] n);
    case (n)
      4'd1:    return CLK_HZ / (2 * 262);
      4'd2:    return CLK_HZ / (2 * 294);
      4'd3:    return CLK_HZ / (2 * 330);
      4'd4:    return CLK_HZ / (2 * 349);
      4'd5:    return CLK_HZ / (2 * 392);
      4'd6:    return CLK_HZ / (2 * 440);
      4'd7:    return CLK_HZ / (2 * 494);
      default: return 0;
    endcase
  endfunction

  // Octave-adjusted half-period of the registered note, plus change detection.
  // tgt_snd looks at the incoming code, so it describes the note the
  // registers will hold after this edge.
  always_comb begin
    eff_half = '0;
    case (oct_q)
      2'b01:   eff_half = CNT_W'(half_of(note_q) << 1);
      2'b10:   eff_half = CNT_W'(half_of(note_q) >> 1);
      default: eff_half = CNT_W'(half_of(note_q));
    endcase
    change  = ({note_in, octave_in} != {note_q, oct_q});
    tgt_snd = enable && (note_in >= 4'd1) && (note_in <= 4'd7);
  end

  // Input registers and IDLE/GAP/TONE sequencing with registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      note_q   <= '0;
      oct_q    <= '0;
      gap_cnt  <= '0;
      half_cnt <= '0;
      speaker  <= 1'b0;
      active   <= 1'b0;
      cur_note <= '0;
    end else begin
      note_q <= note_in;
      oct_q  <= octave_in;
      if (!enable) begin
        state    <= IDLE;
        gap_cnt  <= '0;
        half_cnt <= '0;
        speaker  <= 1'b0;
        active   <= 1'b0;
        cur_note <= '0;
      end else begin
        case (state)
          IDLE: begin
            gap_cnt  <= '0;
            half_cnt <= '0;
            if (tgt_snd) state <= GAP;
          end
          GAP: begin
            if (change && !tgt_snd) begin
              state   <= IDLE;
              gap_cnt <= '0;
            end else if (change) begin
              gap_cnt <= '0;
            end else if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
              // Entry only happens without a change, so note_q is stable.
              state    <= TONE;
              gap_cnt  <= '0;
              half_cnt <= '0;
              speaker  <= 1'b0;
              active   <= 1'b1;
              cur_note <= note_q;
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end
          TONE: begin
            if (change) begin
              state    <= tgt_snd ? GAP : IDLE;
              gap_cnt  <= '0;
              half_cnt <= '0;
              speaker  <= 1'b0;
              active   <= 1'b0;
              cur_note <= '0;
            end else if (half_cnt == eff_half - 1'b1) begin
              half_cnt <= '0;
              speaker  <= ~speaker;
            end else begin
              half_cnt <= half_cnt + 1'b1;
            end
          end
          default: begin
            state    <= IDLE;
            gap_cnt  <= '0;
            half_cnt <= '0;
            speaker  <= 1'b0;
            active   <= 1'b0;
            cur_note <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tone_generator.sv
// tb_tone_generator: randomized scenarios checked against a timing model
// derived from note frequencies, octave scaling and the gap length.
module tb_tone_generator;

  localparam int unsigned CLK_HZ = 1_000_000;
  localparam int unsigned GAPC   = 100;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [3:0] note_in;
  logic [1:0] octave_in;
  logic       speaker;
  logic       active;
  logic [3:0] cur_note;

  int checks;
  int errors;
  int cur_n;
  int cur_o;

  tone_generator #(
    .CLK_HZ    (CLK_HZ),
    .GAP_CYCLES(GAPC),
    .CNT_W     (20)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .note_in  (note_in),
    .octave_in(octave_in),
    .speaker  (speaker),
    .active   (active),
    .cur_note (cur_note)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: toggle spacing in cycles for a note code and octave.
  function automatic int ref_half(input int n, input int o);
    int freq [8] = '{0, 262, 294, 330, 349, 392, 440, 494};
    int h;
    h = CLK_HZ / (2 * freq[n]);
    if (o == 1) return h * 2;
    if (o == 2) return h / 2;
    return h;
  endfunction

  // Negedges until speaker changes; -1 if bound expires first.
  task automatic wait_toggle(input int bound, output int n);
    logic prev;
    prev = speaker;
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      if (speaker !== prev) return;
      if (n >= bound) begin
        n = -1;
        return;
      end
    end
  endtask

  // Stimulus was applied 'used' negedges ago; expect gap, first toggle, one period.
  task automatic play_check(input int n, input int o, input int used);
    int h, got;
    h = ref_half(n, o);
    wait_toggle(GAPC + 1 + h - used + 20, got);
    check("first_edge", got, GAPC + 1 + h - used);
    check("active_on", int'(active), 1);
    check("cur_note", int'(cur_note), n);
    wait_toggle(h + 20, got);
    check("period", got, h);
  endtask

  task automatic apply(input int n, input int o);
    note_in   = 4'(n);
    octave_in = 2'(o);
    cur_n = n;
    cur_o = o;
  endtask

  task automatic pick(output int n, output int o);
    do begin
      n = $urandom_range(1, 7);
      o = $urandom_range(0, 3);
    end while (n == cur_n && o == cur_o);
  endtask

  task automatic check_silent(input string tag);
    check({tag, "_spk"}, int'(speaker), 0);
    check({tag, "_act"}, int'(active), 0);
    check({tag, "_cur"}, int'(cur_note), 0);
  endtask

  initial begin
    int n, o, n2, o2, k, got, kind;
    int silent_codes [5] = '{0, 8, 9, 12, 15};
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    enable = 1'b1;
    cur_n  = 0;
    cur_o  = 0;
    apply(6, 0);
    repeat (3) @(negedge clk);
    check_silent("reset");
    reset = 1'b1;
    play_check(6, 0, 0);

    for (int i = 0; i < 6; i++) begin
      kind = $urandom_range(0, 3);
      pick(n, o);
      case (kind)
        0: begin
          apply(n, o);
          @(negedge clk);
          check("chg_spk", int'(speaker), 0);
          check("chg_act", int'(active), 0);
          play_check(n, o, 1);
        end
        1: begin
          apply(n, o);
          k = $urandom_range(1, GAPC - 1);
          repeat (k) @(negedge clk);
          check("gap_spk", int'(speaker), 0);
          check("gap_act", int'(active), 0);
          pick(n2, o2);
          apply(n2, o2);
          play_check(n2, o2, 0);
        end
        2: begin
          apply(silent_codes[$urandom_range(0, 4)], o);
          @(negedge clk);
          check_silent("silence");
          wait_toggle(150, got);
          check("silent_hold", got, -1);
          pick(n, o);
          apply(n, o);
          play_check(n, o, 0);
        end
        default: begin
          enable = 1'b0;
          apply(n, o);
          @(negedge clk);
          check_silent("en_off");
          wait_toggle(20, got);
          check("en_hold", got, -1);
          enable = 1'b1;
          play_check(n, o, 0);
        end
      endcase
    end

    // Reset mid-tone while speaker is high must clear outputs without a clock.
    wait_toggle(4000, got);
    check("reset_hi", int'(speaker), 1);
    #2 reset = 1'b0;
    #1 check_silent("async_rst");
    o = $urandom_range(0, 3);
    apply(7, o);
    @(negedge clk);
    reset = 1'b1;
    play_check(7, o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
